// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM encoding and BCD constants.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam int         READING_W   = 8;

endpackage

// File: rtl/bcd_dec_digit.sv
// Combinational single-digit BCD decrementer; 0 with borrow wraps to 9.
module bcd_dec_digit
    import timer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] result,
    output logic       borrow_out
);

    always_comb begin
        result     = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                result     = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                result = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer: one decrement per CLK_FREQ running cycles,
// stops at 00 with a sticky expired flag and a one-cycle done pulse.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int CLK_FREQ = 100000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [READING_W-1:0] load_value,
    input  logic                 count_enabled,
    output logic [READING_W-1:0] time_reading,
    output logic                 expired,
    output logic                 done_pulse
);

    localparam int            PW      = $clog2(CLK_FREQ);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_FREQ - 1);

    state_t                 state;
    logic [PW-1:0]          prescaler;
    logic                   tick;
    logic [3:0]             ones_next;
    logic [3:0]             tens_next;
    logic                   ones_borrow;
    logic                   tens_borrow;
    logic [READING_W-1:0]   next_reading;
    logic                   reach_zero;

    function automatic logic [READING_W-1:0] sat_bcd(input logic [READING_W-1:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = (v[7:4] > BCD_MAX) ? BCD_MAX : v[7:4];
        lo = (v[3:0] > BCD_MAX) ? BCD_MAX : v[3:0];
        return {hi, lo};
    endfunction

    assign tick = (state == RUNNING) && (prescaler == PRE_MAX);

    bcd_dec_digit u_ones (
        .digit      (time_reading[3:0]),
        .borrow_in  (tick),
        .result     (ones_next),
        .borrow_out (ones_borrow)
    );

    bcd_dec_digit u_tens (
        .digit      (time_reading[7:4]),
        .borrow_in  (ones_borrow),
        .result     (tens_next),
        .borrow_out (tens_borrow)
    );

    assign next_reading = {tens_next, ones_next};
    // A tens borrow would mean 00 was decremented, which the FSM never allows.
    assign reach_zero   = tick && (next_reading == '0) && !tens_borrow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            prescaler    <= '0;
            time_reading <= '0;
            expired      <= 1'b0;
            done_pulse   <= 1'b0;
        end else if (load) begin
            state        <= IDLE;
            prescaler    <= '0;
            time_reading <= sat_bcd(load_value);
            expired      <= 1'b0;
            done_pulse   <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (count_enabled && (time_reading != '0))
                        state <= RUNNING;
                end
                RUNNING: begin
                    // Prescaler is kept on pause so counting resumes mid-second.
                    prescaler <= tick ? '0 : prescaler + PW'(1);
                    if (tick)
                        time_reading <= next_reading;
                    if (reach_zero) begin
                        expired    <= 1'b1;
                        done_pulse <= 1'b1;
                        state      <= EXPIRED;
                    end else if (!count_enabled) begin
                        state <= IDLE;
                    end
                end
                EXPIRED: begin
                    state <= EXPIRED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
